// File: rtl/stage0_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage0_fetch_pkg
// Purpose  : Instruction field layout, source-select codes and FSM encoding
// Revision : 1.0 - initial release
// ============================================================================
package stage0_fetch_pkg;

   localparam int INSTR_W      = 32;
   localparam int MB_S1_HI     = 31;
   localparam int MB_S1_LO     = 30;
   localparam int MB_S2_HI     = 29;
   localparam int MB_S2_LO     = 28;
   localparam int ALU_HI       = 27;
   localparam int ALU_LO       = 24;
   localparam int VR_HI        = 23;
   localparam int VR_LO        = 16;
   localparam int IMM_HI       = 15;
   localparam int IMM_LO       = 0;

   localparam logic [1:0] MBLOCK_RAM   = 2'd0;
   localparam logic [1:0] MBLOCK_IO    = 2'd2;
   localparam logic [1:0] MBLOCK_CONST = 2'd3;

   localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_VALID  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/stage0_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : stage0_fetch_if
// Purpose  : Program-memory, STAGE1 and redirect signals of the fetch stage
// Revision : 1.0 - initial release
// ============================================================================
interface stage0_fetch_if #(
   parameter int PC_WIDTH = 16
);
   logic                rom_req;
   logic [PC_WIDTH-1:0] rom_addr;
   logic                rom_ack;
   logic [31:0]         rom_data;
   logic                s0_valid;
   logic                s1_ready;
   logic [1:0]          mblock_s1;
   logic [7:0]          vr_source;
   logic [1:0]          mblock_s2;
   logic [3:0]          alu_op;
   logic [15:0]         imm;
   logic [PC_WIDTH-1:0] pc_out;
   logic                branch_take;
   logic [PC_WIDTH-1:0] branch_target;
   logic                halted;

   modport master (
      output rom_req, rom_addr, s0_valid, mblock_s1, vr_source, mblock_s2,
             alu_op, imm, pc_out, halted,
      input  rom_ack, rom_data, s1_ready, branch_take, branch_target
   );

   modport slave (
      input  rom_req, rom_addr, s0_valid, mblock_s1, vr_source, mblock_s2,
             alu_op, imm, pc_out, halted,
      output rom_ack, rom_data, s1_ready, branch_take, branch_target
   );
endinterface
`default_nettype wire

// File: rtl/stage0_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode
// Purpose  : Slices a 32-bit instruction word into stage fields + HALT flag
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode
   import stage0_fetch_pkg::*;
#(
   parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  wire logic [INSTR_W-1:0] i_instr,
   output logic [1:0]              o_mblock_s1,
   output logic [1:0]              o_mblock_s2,
   output logic [3:0]              o_alu_op,
   output logic [7:0]              o_vr_source,
   output logic [15:0]             o_imm,
   output logic                    o_is_halt
);
   assign o_mblock_s1 = i_instr[MB_S1_HI:MB_S1_LO];
   assign o_mblock_s2 = i_instr[MB_S2_HI:MB_S2_LO];
   assign o_alu_op    = i_instr[ALU_HI:ALU_LO];
   assign o_vr_source = i_instr[VR_HI:VR_LO];
   assign o_imm       = i_instr[IMM_HI:IMM_LO];
   assign o_is_halt   = (i_instr[ALU_HI:ALU_LO] == HALT_OPCODE);
endmodule
`default_nettype wire

// File: rtl/stage0_fetch.sv
`default_nettype none
// ============================================================================
// Module   : stage0_fetch
// Purpose  : PC, program-memory fetch, decode and STAGE1 handshake with redirect
// Revision : 1.0 - initial release
// ============================================================================
module stage0_fetch
   import stage0_fetch_pkg::*;
#(
   parameter int         PC_WIDTH    = 16,
   parameter int         RESET_PC    = 0,
   parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   stage0_fetch_if.master  bus
);
   localparam logic [PC_WIDTH-1:0] C_RESET_PC = PC_WIDTH'(RESET_PC);

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] r_pc_out;
   logic [PC_WIDTH-1:0] r_rom_addr;
   logic [INSTR_W-1:0]  r_instr;
   logic                r_rom_req;
   logic                r_kill;
   logic                r_s0_valid;
   logic                r_halted;

   logic                w_ack;
   logic                w_is_halt;
   logic [1:0]          w_mblock_s1;
   logic [1:0]          w_mblock_s2;
   logic [3:0]          w_alu_op;
   logic [7:0]          w_vr_source;
   logic [15:0]         w_imm;

   // Acks with no request outstanding are ignored.
   assign w_ack = bus.rom_ack & r_rom_req;

   instr_decode #(.HALT_OPCODE(HALT_OPCODE)) u_decode (
      .i_instr     (r_instr),
      .o_mblock_s1 (w_mblock_s1),
      .o_mblock_s2 (w_mblock_s2),
      .o_alu_op    (w_alu_op),
      .o_vr_source (w_vr_source),
      .o_imm       (w_imm),
      .o_is_halt   (w_is_halt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_FETCH;
         r_pc       <= C_RESET_PC;
         r_pc_out   <= '0;
         r_rom_addr <= C_RESET_PC;
         r_instr    <= '0;
         r_rom_req  <= 1'b0;
         r_kill     <= 1'b0;
         r_s0_valid <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (bus.branch_take) begin
                  r_pc <= bus.branch_target;
                  if (w_ack) begin
                     r_rom_req <= 1'b0;
                     r_kill    <= 1'b0;
                  end else if (r_rom_req) begin
                     // Address must hold until the in-flight read completes.
                     r_kill <= 1'b1;
                  end else begin
                     r_rom_req  <= 1'b1;
                     r_rom_addr <= bus.branch_target;
                  end
               end else if (w_ack) begin
                  r_rom_req <= 1'b0;
                  if (r_kill) begin
                     r_kill <= 1'b0;
                  end else begin
                     r_instr    <= bus.rom_data;
                     r_pc_out   <= r_pc;
                     r_pc       <= r_pc + PC_WIDTH'(1);
                     r_s0_valid <= 1'b1;
                     r_state    <= ST_VALID;
                  end
               end else if (!r_rom_req) begin
                  r_rom_req  <= 1'b1;
                  r_rom_addr <= r_pc;
               end
            end
            ST_VALID: begin
               if (bus.branch_take) begin
                  r_pc       <= bus.branch_target;
                  r_s0_valid <= 1'b0;
                  r_rom_req  <= 1'b1;
                  r_rom_addr <= bus.branch_target;
                  r_state    <= ST_FETCH;
               end else if (bus.s1_ready) begin
                  r_s0_valid <= 1'b0;
                  if (w_is_halt) begin
                     r_halted <= 1'b1;
                     r_state  <= ST_HALTED;
                  end else begin
                     r_rom_req  <= 1'b1;
                     r_rom_addr <= r_pc;
                     r_state    <= ST_FETCH;
                  end
               end
            end
            ST_HALTED: begin
               if (bus.branch_take) begin
                  r_pc       <= bus.branch_target;
                  r_halted   <= 1'b0;
                  r_rom_req  <= 1'b1;
                  r_rom_addr <= bus.branch_target;
                  r_state    <= ST_FETCH;
               end
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   assign bus.rom_req   = r_rom_req;
   assign bus.rom_addr  = r_rom_addr;
   assign bus.s0_valid  = r_s0_valid;
   assign bus.halted    = r_halted;
   assign bus.pc_out    = r_pc_out;
   assign bus.mblock_s1 = w_mblock_s1;
   assign bus.mblock_s2 = w_mblock_s2;
   assign bus.alu_op    = w_alu_op;
   assign bus.vr_source = w_vr_source;
   assign bus.imm       = w_imm;
endmodule
`default_nettype wire

// File: tb/tb_stage0_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage0_fetch
// Purpose  : Directed self-checking bench for the fetch/decode stage
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage0_fetch;
   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   stage0_fetch_if #(.PC_WIDTH(16)) bus ();

   stage0_fetch #(.PC_WIDTH(16), .RESET_PC(0), .HALT_OPCODE(4'hF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic ack_word(input logic [31:0] w);
      bus.rom_ack  = 1'b1;
      bus.rom_data = w;
      @(negedge clk);
      bus.rom_ack  = 1'b0;
      bus.rom_data = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset rom_req",  32'(bus.rom_req), 32'h0);
      chk("reset s0_valid", 32'(bus.s0_valid), 32'h0);
      chk("reset halted",   32'(bus.halted), 32'h0);
      chk("reset pc_out",   32'(bus.pc_out), 32'h0);
      chk("reset imm",      32'(bus.imm), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first rom_req",  32'(bus.rom_req), 32'h1);
      chk("first rom_addr", 32'(bus.rom_addr), 32'h0);
   endtask

   task automatic test_basic();
      @(negedge clk);
      chk("held rom_addr", 32'(bus.rom_addr), 32'h0);
      ack_word(32'hC0210005);
      chk("basic s0_valid",  32'(bus.s0_valid), 32'h1);
      chk("basic mblock_s1", 32'(bus.mblock_s1), 32'h3);
      chk("basic vr_source", 32'(bus.vr_source), 32'h21);
      chk("basic imm",       32'(bus.imm), 32'h5);
      chk("basic alu_op",    32'(bus.alu_op), 32'h0);
      chk("basic pc_out",    32'(bus.pc_out), 32'h0);
      chk("basic rom_req",   32'(bus.rom_req), 32'h0);
   endtask

   task automatic test_stall();
      bus.s1_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall s0_valid", 32'(bus.s0_valid), 32'h1);
         chk("stall vr_source", 32'(bus.vr_source), 32'h21);
         chk("stall rom_req", 32'(bus.rom_req), 32'h0);
      end
      bus.s1_ready = 1'b1;
      @(negedge clk);
      bus.s1_ready = 1'b0;
      chk("accept s0_valid", 32'(bus.s0_valid), 32'h0);
      chk("accept rom_req",  32'(bus.rom_req), 32'h1);
      chk("accept rom_addr", 32'(bus.rom_addr), 32'h1);
   endtask

   task automatic test_kill();
      bus.branch_take   = 1'b1;
      bus.branch_target = 16'h0040;
      @(negedge clk);
      bus.branch_take = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("kill rom_req held", 32'(bus.rom_req), 32'h1);
         chk("kill rom_addr held", 32'(bus.rom_addr), 32'h1);
         if (i < 2) @(negedge clk);
      end
      ack_word(32'h12345678);
      chk("kill s0_valid", 32'(bus.s0_valid), 32'h0);
      chk("kill rom_req gap", 32'(bus.rom_req), 32'h0);
      @(negedge clk);
      chk("kill re-req", 32'(bus.rom_req), 32'h1);
      chk("kill re-addr", 32'(bus.rom_addr), 32'h40);
      chk("kill s0_valid 2", 32'(bus.s0_valid), 32'h0);
      ack_word(32'h80AA0007);
      chk("target s0_valid",  32'(bus.s0_valid), 32'h1);
      chk("target mblock_s1", 32'(bus.mblock_s1), 32'h2);
      chk("target vr_source", 32'(bus.vr_source), 32'hAA);
      chk("target imm",       32'(bus.imm), 32'h7);
      chk("target pc_out",    32'(bus.pc_out), 32'h40);
   endtask

   task automatic test_branch_accept();
      bus.s1_ready      = 1'b1;
      bus.branch_take   = 1'b1;
      bus.branch_target = 16'h0020;
      @(negedge clk);
      bus.s1_ready    = 1'b0;
      bus.branch_take = 1'b0;
      chk("brv s0_valid", 32'(bus.s0_valid), 32'h0);
      chk("brv rom_req",  32'(bus.rom_req), 32'h1);
      chk("brv rom_addr", 32'(bus.rom_addr), 32'h20);
      @(negedge clk);
      chk("brv s0_valid 2", 32'(bus.s0_valid), 32'h0);
   endtask

   task automatic test_halt();
      ack_word(32'h0F330009);
      chk("halt word valid",  32'(bus.s0_valid), 32'h1);
      chk("halt word alu_op", 32'(bus.alu_op), 32'hF);
      chk("halt word pc_out", 32'(bus.pc_out), 32'h20);
      chk("halt not yet",     32'(bus.halted), 32'h0);
      bus.s1_ready = 1'b1;
      @(negedge clk);
      bus.s1_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("halted", 32'(bus.halted), 32'h1);
         chk("halted rom_req", 32'(bus.rom_req), 32'h0);
         chk("halted s0_valid", 32'(bus.s0_valid), 32'h0);
         @(negedge clk);
      end
      bus.branch_take   = 1'b1;
      bus.branch_target = 16'h0010;
      @(negedge clk);
      bus.branch_take = 1'b0;
      chk("unhalt halted",   32'(bus.halted), 32'h0);
      chk("unhalt rom_req",  32'(bus.rom_req), 32'h1);
      chk("unhalt rom_addr", 32'(bus.rom_addr), 32'h10);
   endtask

   task automatic test_wrap();
      bus.branch_take   = 1'b1;
      bus.branch_target = 16'hFFFF;
      ack_word(32'h11111111);
      bus.branch_take = 1'b0;
      chk("brack s0_valid", 32'(bus.s0_valid), 32'h0);
      chk("brack rom_req",  32'(bus.rom_req), 32'h0);
      @(negedge clk);
      chk("brack re-req",  32'(bus.rom_req), 32'h1);
      chk("brack re-addr", 32'(bus.rom_addr), 32'hFFFF);
      ack_word(32'hC0FF1234);
      chk("wrap s0_valid",  32'(bus.s0_valid), 32'h1);
      chk("wrap pc_out",    32'(bus.pc_out), 32'hFFFF);
      chk("wrap vr_source", 32'(bus.vr_source), 32'hFF);
      chk("wrap imm",       32'(bus.imm), 32'h1234);
      bus.s1_ready = 1'b1;
      @(negedge clk);
      bus.s1_ready = 1'b0;
      chk("wrap rom_req",  32'(bus.rom_req), 32'h1);
      chk("wrap rom_addr", 32'(bus.rom_addr), 32'h0);
   endtask

   task automatic test_reset_mid();
      ack_word(32'h00000001);
      chk("pre-reset pc_out", 32'(bus.pc_out), 32'h0);
      bus.s1_ready = 1'b1;
      @(negedge clk);
      bus.s1_ready = 1'b0;
      chk("pre-reset rom_addr", 32'(bus.rom_addr), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst rom_req",  32'(bus.rom_req), 32'h0);
      chk("mid rst rom_addr", 32'(bus.rom_addr), 32'h0);
      chk("mid rst imm",      32'(bus.imm), 32'h0);
      chk("mid rst s0_valid", 32'(bus.s0_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart rom_req",  32'(bus.rom_req), 32'h1);
      chk("restart rom_addr", 32'(bus.rom_addr), 32'h0);
      ack_word(32'hC0210005);
      chk("restart s0_valid", 32'(bus.s0_valid), 32'h1);
      chk("restart pc_out",   32'(bus.pc_out), 32'h0);
   endtask

   initial begin
      tests_run         = 0;
      tests_failed      = 0;
      rst_n             = 1'b0;
      bus.rom_ack       = 1'b0;
      bus.rom_data      = 32'h0;
      bus.s1_ready      = 1'b0;
      bus.branch_take   = 1'b0;
      bus.branch_target = 16'h0;
      test_reset();
      test_basic();
      test_stall();
      test_kill();
      test_branch_accept();
      test_halt();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire
